noc_output_port_tx: RTL and testbench
=====================================

# noc_output_port_tx

Credit-based link transmitter for one NoC router output port. It accepts flits from the crossbar side into a small FIFO and drives them onto the inter-router link. It tracks free slots in the downstream `inputbuffers` instance with a credit counter and returns nothing upstream except backpressure. It sits between the switch allocator/crossbar output and the physical link whose far end is the neighbouring router's input buffer.

## Interface
- `FLIT_W`, 34: flit width; bit 33 = head, bit 32 = tail, [31:0] = payload.
- `FIFO_DEPTH`, 4: local staging FIFO entries; power of two, at least 2.
- `CREDITS`, 4: downstream input-buffer depth; initial and maximum credit count.
- `CNT_W`, 3: credit counter width; must hold `CREDITS`.

- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_flit`, in, `FLIT_W`: flit from the crossbar.
- `in_valid`, in, 1: `in_flit` is valid.
- `in_ready`, out, 1: FIFO can accept a flit.
- `link_flit`, out, `FLIT_W`: registered flit to the downstream input buffer.
- `link_valid`, out, 1: registered; `link_flit` is valid for exactly this cycle.
- `credit_in`, in, 1: one-cycle pulse; the downstream buffer freed one slot.
- `credits_avail`, out, `CNT_W`: current credit count.
- `pkt_active`, out, 1: a packet has been started on the link but its tail has not been sent.

## Operation
- Enqueue on `in_valid && in_ready`. `in_ready` is `!fifo_full`, combinational from registered state only. It does not depend on a same-cycle dequeue, so there is no fall-through.
- Send condition: `fifo_nonempty && credit_cnt != 0`, evaluated on registered state. On send:
  - the FIFO head is popped and loaded into `link_flit`;
  - `link_valid` is set to 1 for one cycle;
  - `credit_cnt` decrements.
- When not sending, `link_valid` is 0 and `link_flit` holds its last value.
- Credit update at each edge:
  - send only: decrement by 1;
  - `credit_in` only: increment by 1;
  - both: count unchanged.
- A `credit_in` arriving while the count equals `CREDITS` (with no same-cycle send) is dropped. The count saturates at `CREDITS`.
- Packet FSM, advanced only on send:
  - IDLE + head without tail -> PKT.
  - IDLE + head with tail (single-flit packet) -> IDLE.
  - PKT + tail -> IDLE.
  - PKT + body -> PKT.
  - `pkt_active = (state == PKT)`.
- Malformed sequences (head in PKT, body in IDLE) are transmitted unchanged. The FSM follows the rules above and ignores the head bit while in PKT.
- Simultaneous enqueue and dequeue on a full FIFO: the dequeue occurs and the enqueue does not, because `in_ready` was 0.

## Timing
- Reset values:
  - `link_valid` = 0, `link_flit` = 0;
  - `in_ready` = 1;
  - `credits_avail` = `CREDITS`;
  - `pkt_active` = 0;
  - FIFO empty, FSM IDLE.
- Reset assertion mid-packet clears all state immediately and asynchronously. Any flits in flight are discarded.
- Latency: a flit accepted at edge N is sent at edge N+1 at the earliest, so `link_valid` is high in the cycle after edge N+1.
- Throughput: one flit per cycle while credits are greater than 0.
- A credit pulse sampled at edge N makes a send possible at edge N+1 when the count was 0. Zero-credit turnaround is therefore one cycle after the credit edge.
- `credits_avail` reflects the post-edge count.
- The FIFO pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer bit.

## Configuration
- `NOC_TX_CREDIT_CHECK_EN` defined:
  - adds output `err_credit_ovf` (1 bit, reset 0);
  - the flag is sticky and sets at the edge where `credit_in` is sampled with count == `CREDITS` and no same-cycle send;
  - it clears only on reset.
- Undefined: the port and its logic are absent. The overflowing credit is silently dropped.

## Test plan
- Reset, then push 4 flits (head 0x1, body 0x2, body 0x3, tail 0x4) with no `credit_in`:
  - `link_valid` is high for 4 consecutive cycles starting 2 edges after the first push;
  - `credits_avail` steps 4 to 0;
  - `pkt_active` goes high after the head and low after the tail.
- With 0 credits, push 5 flits:
  - `in_ready` goes low after the 4th (FIFO full) and no `link_valid` occurs;
  - pulse `credit_in` once: exactly one flit is sent the cycle after, `in_ready` returns to 1, and `credits_avail` stays 0.
- With credits = 2 and FIFO non-empty, assert `credit_in` on the same edge as a send: `credits_avail` stays 2.
- Single-flit packet (head and tail both set): `pkt_active` never rises; `credits_avail` goes 4 to 3.
- Assert `rst_n` low mid-packet with 2 flits queued:
  - the outputs return to their reset values immediately, without waiting for a clock;
  - after release, no stale flit appears on the link.
- With `NOC_TX_CREDIT_CHECK_EN` defined, pulse `credit_in` at count 4:
  - `err_credit_ovf` goes to 1 and stays at 1;
  - `credits_avail` stays 4.

Source files
------------

// File: rtl/noc_output_port_tx.sv
// noc_output_port_tx
// Credit-based link transmitter for one NoC router output port.
// Flits from the crossbar are staged in a small FIFO. They are then
// launched onto the link whenever the downstream input buffer has a
// free slot, which is tracked by a saturating credit counter.
// Optional build macro: NOC_TX_CREDIT_CHECK_EN adds a sticky
// err_credit_ovf flag. The flag is raised when a credit arrives while
// the counter is already full and nothing is being sent.
module noc_output_port_tx #(
  parameter int FLIT_W     = 34,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] link_flit,
  output logic              link_valid,
  input  logic              credit_in,
  output logic [CNT_W-1:0]  credits_avail,
  output logic              pkt_active
`ifdef NOC_TX_CREDIT_CHECK_EN
  ,
  output logic              err_credit_ovf
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  // Staging FIFO storage. The pointers carry one extra wrap bit so that
  // a full FIFO and an empty FIFO can be told apart.
  logic [FLIT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [CNT_W-1:0]  credit_cnt;
  state_t            state;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              send;
  logic [FLIT_W-1:0] head_flit;
  logic              flit_is_head;
  logic              flit_is_tail;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // in_ready depends only on registered state. A pop in the same cycle
  // does not free space early, so there is no fall-through path.
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign send     = !fifo_empty && (credit_cnt != '0);

  assign head_flit    = mem[rd_ptr[AW-1:0]];
  assign flit_is_head = head_flit[FLIT_W-1];
  assign flit_is_tail = head_flit[FLIT_W-2];

  assign credits_avail = credit_cnt;
  assign pkt_active    = (state == PKT);

  // FIFO data write. The storage is not reset; only the pointers decide
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_flit;
    end
  end

  // FIFO pointer advance on enqueue and on send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (send) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered link outputs. link_flit keeps its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_flit  <= '0;
      link_valid <= 1'b0;
    end else begin
      link_valid <= send;
      if (send) link_flit <= head_flit;
    end
  end

  // Credit counter. A send and a returning credit cancel each other out.
  // A credit that arrives while the counter is already full is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CREDIT_MAX;
    end else begin
      case ({send, credit_in})
        2'b10:   credit_cnt <= credit_cnt - 1'b1;
        2'b01:   if (credit_cnt != CREDIT_MAX) credit_cnt <= credit_cnt + 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // Packet-framing FSM. It advances only on a send, and it ignores the
  // head bit while a packet is already open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (send) begin
      case (state)
        IDLE:    if (flit_is_head && !flit_is_tail) state <= PKT;
        PKT:     if (flit_is_tail) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOC_TX_CREDIT_CHECK_EN
  // Sticky overflow flag. It is raised by a credit that would push the
  // counter past its maximum, and it is cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_credit_ovf <= 1'b0;
    end else if (credit_in && !send && (credit_cnt == CREDIT_MAX)) begin
      err_credit_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_output_port_tx.sv
// Directed testbench for noc_output_port_tx.
// Flits accepted by the DUT are pushed into a scoreboard queue. Each
// link_valid cycle pops the queue and compares the flit on the link.
module tb_noc_output_port_tx;

  logic        clk;
  logic        rst_n;
  logic [33:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] link_flit;
  logic        link_valid;
  logic        credit_in;
  logic [2:0]  credits_avail;
  logic        pkt_active;
`ifdef NOC_TX_CREDIT_CHECK_EN
  logic        err_credit_ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  noc_output_port_tx #(
    .FLIT_W(34), .FIFO_DEPTH(4), .CREDITS(4), .CNT_W(3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_flit       (in_flit),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .link_flit     (link_flit),
    .link_valid    (link_valid),
    .credit_in     (credit_in),
    .credits_avail (credits_avail),
    .pkt_active    (pkt_active)
`ifdef NOC_TX_CREDIT_CHECK_EN
    ,
    .err_credit_ovf(err_credit_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] mk(input logic h, input logic t, input logic [31:0] p);
    return {h, t, p};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Before the edge, a flit the DUT is about to accept
  // goes into the scoreboard. After the edge, any flit on the link is
  // compared against the oldest expected entry.
  task automatic cycle();
    logic [33:0] e;
    if (in_valid && in_ready) exp_q.push_back(in_flit);
    @(posedge clk);
    #1;
    if (link_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_flit", 64'(link_flit), 64'h3_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_link_flit", 64'(link_flit), 64'(e));
      end
      $display("tx flit 0x%09h credits=%0d pkt_active=%0b", link_flit, credits_avail, pkt_active);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_flit   = '0;
    in_valid  = 1'b0;
    credit_in = 1'b0;
    #12;
    // Reset state.
    check("rst_link_valid", 64'(link_valid), 64'd0);
    check("rst_link_flit", 64'(link_flit), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_credits", 64'(credits_avail), 64'd4);
    check("rst_pkt_active", 64'(pkt_active), 64'd0);
`ifdef NOC_TX_CREDIT_CHECK_EN
    check("rst_err_ovf", 64'(err_credit_ovf), 64'd0);
`endif
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: a 4-flit packet drains with no returning credits.
    in_valid = 1'b1;
    in_flit = mk(1'b1, 1'b0, 32'h1); cycle();
    check("t1_lv_e1", 64'(link_valid), 64'd0);
    check("t1_cr_e1", 64'(credits_avail), 64'd4);
    in_flit = mk(1'b0, 1'b0, 32'h2); cycle();
    check("t1_lv_e2", 64'(link_valid), 64'd1);
    check("t1_cr_e2", 64'(credits_avail), 64'd3);
    check("t1_pa_e2", 64'(pkt_active), 64'd1);
    in_flit = mk(1'b0, 1'b0, 32'h3); cycle();
    check("t1_lv_e3", 64'(link_valid), 64'd1);
    check("t1_cr_e3", 64'(credits_avail), 64'd2);
    in_flit = mk(1'b0, 1'b1, 32'h4); cycle();
    check("t1_lv_e4", 64'(link_valid), 64'd1);
    check("t1_cr_e4", 64'(credits_avail), 64'd1);
    check("t1_pa_e4", 64'(pkt_active), 64'd1);
    in_valid = 1'b0; cycle();
    check("t1_lv_e5", 64'(link_valid), 64'd1);
    check("t1_cr_e5", 64'(credits_avail), 64'd0);
    check("t1_pa_e5", 64'(pkt_active), 64'd0);
    cycle();
    check("t1_lv_e6", 64'(link_valid), 64'd0);

    // Test 2: with no credits, the FIFO fills and nothing is sent.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_flit = mk(1'b0, 1'b0, 32'h10 + 32'(i));
      cycle();
      check("t2_no_send", 64'(link_valid), 64'd0);
      if (i >= 3) check("t2_in_ready_full", 64'(in_ready), 64'd0);
      else        check("t2_in_ready", 64'(in_ready), 64'd1);
    end
    // Flit 0x14 is held on in_flit. A single credit pulse releases one flit.
    credit_in = 1'b1; cycle(); credit_in = 1'b0;
    check("t2_cr_after_pulse", 64'(credits_avail), 64'd1);
    check("t2_lv_pulse_edge", 64'(link_valid), 64'd0);
    cycle();
    check("t2_lv_one_send", 64'(link_valid), 64'd1);
    check("t2_in_ready_back", 64'(in_ready), 64'd1);
    check("t2_cr_zero", 64'(credits_avail), 64'd0);
    cycle();  // flit 0x14 is enqueued and the FIFO is full again
    check("t2_lv_after", 64'(link_valid), 64'd0);
    check("t2_full_again", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    // Drain the FIFO by returning credits. The scoreboard checks each flit.
    credit_in = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    credit_in = 1'b0;
    check("t2_drain_cr", 64'(credits_avail), 64'd3);
    check("t2_drain_empty", 64'(exp_q.size()), 64'd0);

    // Test 3: a credit on the same edge as a send leaves the count unchanged.
    in_valid = 1'b1;
    in_flit = mk(1'b0, 1'b0, 32'h30); cycle();
    in_flit = mk(1'b0, 1'b0, 32'h31); cycle();
    in_valid = 1'b0;
    check("t3_cr_two", 64'(credits_avail), 64'd2);
    credit_in = 1'b1; cycle(); credit_in = 1'b0;
    check("t3_lv_send", 64'(link_valid), 64'd1);
    check("t3_cr_kept", 64'(credits_avail), 64'd2);
    cycle();
    check("t3_cr_idle", 64'(credits_avail), 64'd2);
    credit_in = 1'b1; cycle(); cycle(); credit_in = 1'b0;
    check("t3_cr_full", 64'(credits_avail), 64'd4);

    // Overflow: a credit that arrives at the maximum count is dropped.
    credit_in = 1'b1; cycle(); credit_in = 1'b0;
    check("ovf_cr_sat", 64'(credits_avail), 64'd4);
`ifdef NOC_TX_CREDIT_CHECK_EN
    check("ovf_flag_set", 64'(err_credit_ovf), 64'd1);
    cycle(); cycle();
    check("ovf_flag_sticky", 64'(err_credit_ovf), 64'd1);
`endif

    // Test 4: a single-flit packet never opens a packet.
    in_valid = 1'b1;
    in_flit = mk(1'b1, 1'b1, 32'h40); cycle();
    in_valid = 1'b0;
    check("t4_pa_e1", 64'(pkt_active), 64'd0);
    cycle();
    check("t4_lv", 64'(link_valid), 64'd1);
    check("t4_pa_e2", 64'(pkt_active), 64'd0);
    check("t4_cr", 64'(credits_avail), 64'd3);
    cycle();
    check("t4_pa_e3", 64'(pkt_active), 64'd0);

    // Test 5: asynchronous reset in the middle of a packet.
    in_valid = 1'b1;
    in_flit = mk(1'b1, 1'b0, 32'h50); cycle();
    for (int i = 1; i <= 4; i++) begin
      in_flit = mk(1'b0, 1'b0, 32'h50 + 32'(i));
      cycle();
    end
    in_valid = 1'b0;
    check("t5_pa_mid", 64'(pkt_active), 64'd1);
    check("t5_cr_mid", 64'(credits_avail), 64'd0);
    check("t5_queued", 64'(exp_q.size()), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_flit", 64'(link_flit), 64'd0);
    check("t5_async_lv", 64'(link_valid), 64'd0);
    check("t5_async_cr", 64'(credits_avail), 64'd4);
    check("t5_async_pa", 64'(pkt_active), 64'd0);
    check("t5_async_rdy", 64'(in_ready), 64'd1);
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t5_no_stale", 64'(link_valid), 64'd0);
    end
    check("t5_cr_after", 64'(credits_avail), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
